// File: rtl/dcache_writeback_buffer_if.sv
// Bus bundle between the D-cache, the write-back buffer and the memory ports.
// slave = buffer side, master = D-cache/memory (or testbench) side.
interface dcache_writeback_buffer_if #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BLOCK_DW  = 256,
  parameter int unsigned ADDR_BITS = 32
);
  logic                     evict_valid_i;
  logic                     evict_ready_o;
  logic [ADDR_BITS-1:0]     evict_address_i;
  logic [BLOCK_DW-1:0]      evict_data_i;
  logic                     miss_valid_i;
  logic [ADDR_BITS-1:0]     miss_address_i;
  logic                     miss_stall_o;
  logic                     fwd_valid_o;
  logic [ADDR_BITS-1:0]     fwd_address_o;
  logic [BLOCK_DW-1:0]      fwd_data_o;
  logic                     mem_rd_valid_o;
  logic [ADDR_BITS-1:0]     mem_rd_address_o;
  logic                     mem_wr_valid_o;
  logic [ADDR_BITS-1:0]     mem_wr_address_o;
  logic [BLOCK_DW-1:0]      mem_wr_data_o;
  logic                     empty_o;
  logic [$clog2(DEPTH):0]   count_o;

  modport slave (
    input  evict_valid_i, evict_address_i, evict_data_i, miss_valid_i, miss_address_i,
    output evict_ready_o, miss_stall_o, fwd_valid_o, fwd_address_o, fwd_data_o,
           mem_rd_valid_o, mem_rd_address_o, mem_wr_valid_o, mem_wr_address_o,
           mem_wr_data_o, empty_o, count_o
  );

  modport master (
    output evict_valid_i, evict_address_i, evict_data_i, miss_valid_i, miss_address_i,
    input  evict_ready_o, miss_stall_o, fwd_valid_o, fwd_address_o, fwd_data_o,
           mem_rd_valid_o, mem_rd_address_o, mem_wr_valid_o, mem_wr_address_o,
           mem_wr_data_o, empty_o, count_o
  );
endinterface

// File: rtl/dcache_writeback_buffer.sv
// D-cache write-back buffer: FIFO of dirty evictions drained oldest-first, with read-miss
// checking. Define WB_FORWARD_EN to forward hits instead of stalling the miss.
module dcache_writeback_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BLOCK_DW  = 256,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DRAIN_GAP = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  dcache_writeback_buffer_if.slave   bus
);
  localparam int unsigned OFFSET = $clog2(BLOCK_DW / 8);
  localparam int unsigned BAW    = ADDR_BITS - OFFSET;
  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned GW     = (DRAIN_GAP > 0) ? $clog2(DRAIN_GAP + 1) : 1;

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [BAW-1:0]      baddr_q [DEPTH];
  logic [BLOCK_DW-1:0] data_q  [DEPTH];
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [PW:0]         count_q, count_d;
  logic [GW-1:0]       gap_q, gap_d;

  logic [BAW-1:0] ev_baddr, miss_baddr;
  logic           empty, full, drain;
  logic           coal_hit, ready, accept, push;
  logic [PW-1:0]  coal_idx, wr_idx;
  logic           buf_hit, ev_match, hit;
  logic [PW-1:0]  buf_idx;

  assign ev_baddr   = bus.evict_address_i[ADDR_BITS-1:OFFSET];
  assign miss_baddr = bus.miss_address_i[ADDR_BITS-1:OFFSET];
  assign empty      = (count_q == '0);
  assign full       = (count_q == (PW+1)'(DEPTH));
  // Drain is suppressed while reset is asserted so a reset never issues a partial write.
  assign drain      = !empty && (gap_q == '0) && rst_n;

  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (baddr_q[i] == ev_baddr) && !(drain && (PW'(i) == head_q))) begin
        coal_hit = 1'b1;
        coal_idx = PW'(i);
      end
    end
  end

  assign ready  = !full || drain || coal_hit;
  assign accept = bus.evict_valid_i && ready;
  assign push   = accept && !coal_hit;
  assign wr_idx = coal_hit ? coal_idx : tail_q;

  // Walk oldest to newest so the last match left standing is the newest entry.
  always_comb begin
    buf_hit = 1'b0;
    buf_idx = head_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (((PW+1)'(k) < count_q) && valid_q[head_q + PW'(k)] &&
          (baddr_q[head_q + PW'(k)] == miss_baddr)) begin
        buf_hit = 1'b1;
        buf_idx = head_q + PW'(k);
      end
    end
  end

  assign ev_match = accept && (ev_baddr == miss_baddr);
  assign hit      = ev_match || buf_hit;

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    gap_d   = gap_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
      gap_d           = GW'(DRAIN_GAP);
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    case ({push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      gap_q   <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      gap_q   <= gap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      baddr_q[wr_idx] <= ev_baddr;
      data_q[wr_idx]  <= bus.evict_data_i;
    end
  end

  assign bus.evict_ready_o    = ready;
  assign bus.mem_rd_address_o = bus.miss_address_i;
  assign bus.mem_wr_valid_o   = drain;
  assign bus.mem_wr_address_o = {baddr_q[head_q], {OFFSET{1'b0}}};
  assign bus.mem_wr_data_o    = data_q[head_q];
  assign bus.empty_o          = empty;
  assign bus.count_o          = count_q;

`ifdef WB_FORWARD_EN
  logic                 fwd_valid_q;
  logic [ADDR_BITS-1:0] fwd_addr_q;
  logic [BLOCK_DW-1:0]  fwd_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) fwd_valid_q <= 1'b0;
    else        fwd_valid_q <= bus.miss_valid_i && hit;
  end

  always_ff @(posedge clk) begin
    if (bus.miss_valid_i && hit) begin
      fwd_addr_q <= bus.miss_address_i;
      fwd_data_q <= ev_match ? bus.evict_data_i : data_q[buf_idx];
    end
  end

  assign bus.miss_stall_o   = 1'b0;
  assign bus.mem_rd_valid_o = bus.miss_valid_i && !hit;
  assign bus.fwd_valid_o    = fwd_valid_q;
  assign bus.fwd_address_o  = fwd_addr_q;
  assign bus.fwd_data_o     = fwd_data_q;
`else
  assign bus.miss_stall_o   = bus.miss_valid_i && hit;
  assign bus.mem_rd_valid_o = bus.miss_valid_i && !hit;
  assign bus.fwd_valid_o    = 1'b0;
  assign bus.fwd_address_o  = '0;
  assign bus.fwd_data_o     = '0;
`endif
endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// Bench for dcache_writeback_buffer: queue-based reference model plus directed cases.
module tb_dcache_writeback_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 256;
  localparam int unsigned AW    = 32;
  localparam int unsigned OFF   = 5;
  localparam int          GAP   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_writeback_buffer_if #(.DEPTH(DEPTH), .BLOCK_DW(DW), .ADDR_BITS(AW)) bus ();
  dcache_writeback_buffer_if #(.DEPTH(DEPTH), .BLOCK_DW(DW), .ADDR_BITS(AW)) bus15 ();

  dcache_writeback_buffer #(.DEPTH(DEPTH), .BLOCK_DW(DW), .ADDR_BITS(AW), .DRAIN_GAP(GAP))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  dcache_writeback_buffer #(.DEPTH(DEPTH), .BLOCK_DW(DW), .ADDR_BITS(AW), .DRAIN_GAP(15))
    u_dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of buffered blocks, oldest at index 0.
  typedef struct {
    logic [AW-OFF-1:0] ba;
    logic [DW-1:0]     d;
  } ent_t;

  ent_t          mq[$];
  ent_t          ne;
  int            mgap = 0;
  logic          mfwd_v = 1'b0;
  logic [DW-1:0] mfwd_d = '0;
  logic [AW-1:0] mfwd_a = '0;

  logic          e_drain, e_ready, e_acc, e_hit, e_stall, e_rd;
  int            e_coal;
  logic [DW-1:0] e_hd;

  task automatic model_eval();
    int sz;
    logic [AW-OFF-1:0] eb, mb;
    sz = mq.size();
    eb = bus.evict_address_i[AW-1:OFF];
    mb = bus.miss_address_i[AW-1:OFF];
    e_drain = (sz > 0) && (mgap == 0);
    e_coal = -1;
    for (int j = 0; j < sz; j++)
      if (mq[j].ba == eb && !(e_drain && j == 0)) e_coal = j;
    e_ready = (sz < DEPTH) || e_drain || (e_coal >= 0);
    e_acc   = bus.evict_valid_i && e_ready;
    e_hit   = 1'b0;
    e_hd    = '0;
    if (e_acc && eb == mb) begin
      e_hit = 1'b1;
      e_hd  = bus.evict_data_i;
    end else begin
      for (int j = sz - 1; j >= 0; j--)
        if (!e_hit && mq[j].ba == mb) begin
          e_hit = 1'b1;
          e_hd  = mq[j].d;
        end
    end
`ifdef WB_FORWARD_EN
    e_stall = 1'b0;
`else
    e_stall = bus.miss_valid_i && e_hit;
`endif
    e_rd = bus.miss_valid_i && !e_hit;
  endtask

  always @(negedge clk) begin
    model_eval();
    if (rst_n) begin
      check("evict_ready", DW'(bus.evict_ready_o), DW'(e_ready));
      check("mem_wr_valid", DW'(bus.mem_wr_valid_o), DW'(e_drain));
      if (e_drain) begin
        check("mem_wr_addr", DW'(bus.mem_wr_address_o), DW'({mq[0].ba, 5'b0}));
        check("mem_wr_data", bus.mem_wr_data_o, mq[0].d);
      end
      check("miss_stall", DW'(bus.miss_stall_o), DW'(e_stall));
      check("mem_rd_valid", DW'(bus.mem_rd_valid_o), DW'(e_rd));
      if (e_rd) check("mem_rd_addr", DW'(bus.mem_rd_address_o), DW'(bus.miss_address_i));
      check("empty", DW'(bus.empty_o), DW'(mq.size() == 0));
      check("count", DW'(bus.count_o), DW'(mq.size()));
      check("fwd_valid", DW'(bus.fwd_valid_o), DW'(mfwd_v));
      if (mfwd_v) begin
        check("fwd_data", bus.fwd_data_o, mfwd_d);
        check("fwd_addr", DW'(bus.fwd_address_o), DW'(mfwd_a));
      end
    end else begin
      check("rst_no_write", DW'(bus.mem_wr_valid_o), DW'(0));
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mgap   = 0;
      mfwd_v = 1'b0;
    end else begin
`ifdef WB_FORWARD_EN
      mfwd_v = bus.miss_valid_i && e_hit;
      if (mfwd_v) begin
        mfwd_d = e_hd;
        mfwd_a = bus.miss_address_i;
      end
`else
      mfwd_v = 1'b0;
`endif
      if (e_acc && e_coal >= 0) begin
        ne      = mq[e_coal];
        ne.d    = bus.evict_data_i;
        mq[e_coal] = ne;
      end
      if (e_drain) begin
        void'(mq.pop_front());
        mgap = GAP;
      end else if (mgap > 0) begin
        mgap--;
      end
      if (e_acc && e_coal < 0) begin
        ne.ba = bus.evict_address_i[AW-1:OFF];
        ne.d  = bus.evict_data_i;
        mq.push_back(ne);
      end
    end
  end

  // Samples taken mid-cycle by the stimulus tasks.
  logic          s_ready, s_stall, s_rd_v, s_wr_v, s_fwd_v;
  logic [AW-1:0] s_wr_a, s_rd_a;
  logic [DW-1:0] s_wr_d, s_fwd_d;
  logic          s15_ready, s15_wr_v;
  logic [AW-1:0] s15_wr_a;
  logic [DW-1:0] s15_wr_d;

  task automatic step(input logic ev_v, input logic [AW-1:0] ev_a, input logic [DW-1:0] ev_d,
                      input logic m_v, input logic [AW-1:0] m_a);
    bus.evict_valid_i   = ev_v;
    bus.evict_address_i = ev_a;
    bus.evict_data_i    = ev_d;
    bus.miss_valid_i    = m_v;
    bus.miss_address_i  = m_a;
    @(negedge clk);
    s_ready = bus.evict_ready_o;
    s_stall = bus.miss_stall_o;
    s_rd_v  = bus.mem_rd_valid_o;
    s_rd_a  = bus.mem_rd_address_o;
    s_wr_v  = bus.mem_wr_valid_o;
    s_wr_a  = bus.mem_wr_address_o;
    s_wr_d  = bus.mem_wr_data_o;
    s_fwd_v = bus.fwd_valid_o;
    s_fwd_d = bus.fwd_data_o;
    @(posedge clk);
    #1;
  endtask

  task automatic step15(input logic ev_v, input logic [AW-1:0] ev_a, input logic [DW-1:0] ev_d);
    bus15.evict_valid_i   = ev_v;
    bus15.evict_address_i = ev_a;
    bus15.evict_data_i    = ev_d;
    @(negedge clk);
    s15_ready = bus15.evict_ready_o;
    s15_wr_v  = bus15.mem_wr_valid_o;
    s15_wr_a  = bus15.mem_wr_address_o;
    s15_wr_d  = bus15.mem_wr_data_o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.evict_valid_i     = 1'b0;
    bus.evict_address_i   = '0;
    bus.evict_data_i      = '0;
    bus.miss_valid_i      = 1'b0;
    bus.miss_address_i    = '0;
    bus15.evict_valid_i   = 1'b0;
    bus15.evict_address_i = '0;
    bus15.evict_data_i    = '0;
    bus15.miss_valid_i    = 1'b0;
    bus15.miss_address_i  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd_blk();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] waddr[3];
    logic [DW-1:0] wdata[3];
    logic [DW-1:0] dblk, daa;
    int            wcyc[3];
    int            nw, acc_at, nwr;
    logic          hold_v, ev_v, m_v;
    logic [AW-1:0] hold_a, ea, ma;

    do_reset();
    #1;
    check("rst_empty", DW'(bus.empty_o), DW'(1));
    check("rst_ready", DW'(bus.evict_ready_o), DW'(1));
    check("rst_wr_valid", DW'(bus.mem_wr_valid_o), DW'(0));
    check("rst_count", DW'(bus.count_o), DW'(0));
    check("rst_stall", DW'(bus.miss_stall_o), DW'(0));
    check("rst_rd_valid", DW'(bus.mem_rd_valid_o), DW'(0));
    check("rst_fwd_valid", DW'(bus.fwd_valid_o), DW'(0));
    check("rst15_empty", DW'(bus15.empty_o), DW'(1));
    check("rst15_count", DW'(bus15.count_o), DW'(0));
    @(posedge clk);
    #1;

    // Three back-to-back evictions drain in order, three cycles apart.
    nw = 0;
    for (int c = 0; c < 30; c++) begin
      dblk = rnd_blk();
      if (c < 3) step(1'b1, AW'((c + 1) * 32'h100), dblk, 1'b0, '0);
      else       step(1'b0, '0, '0, 1'b0, '0);
      if (c < 3) wdata[c] = dblk;
      if (s_wr_v) begin
        if (nw < 3) begin
          wcyc[nw]  = c;
          waddr[nw] = s_wr_a;
          if (nw == 2) check("drain_empty_after", DW'(bus.empty_o), DW'(1));
          check("drain_data", s_wr_d, wdata[nw]);
        end
        nw++;
      end
    end
    check("drain_writes", DW'(nw), DW'(3));
    for (int i = 0; i < 3; i++) check("drain_addr", DW'(waddr[i]), DW'((i + 1) * 32'h100));
    for (int i = 1; i < 3; i++) check("drain_spacing", DW'(wcyc[i] - wcyc[i-1]), DW'(3));

    // Miss on a buffered block: forward or stall until it has drained.
    do_reset();
    dblk = rnd_blk();
    step(1'b1, 32'h140, dblk, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 32'h140);
`ifdef WB_FORWARD_EN
    check("fwd_no_rd", DW'(s_rd_v), DW'(0));
    check("fwd_no_stall", DW'(s_stall), DW'(0));
    step(1'b0, '0, '0, 1'b0, '0);
    check("fwd_valid_next", DW'(s_fwd_v), DW'(1));
    check("fwd_data_next", s_fwd_d, dblk);
`else
    check("stall_in_drain", DW'(s_stall), DW'(1));
    check("stall_drain_wr", DW'(s_wr_v), DW'(1));
    check("stall_no_rd", DW'(s_rd_v), DW'(0));
    step(1'b0, '0, '0, 1'b1, 32'h140);
    check("stall_released", DW'(s_stall), DW'(0));
    check("stall_rd_after", DW'(s_rd_v), DW'(1));
    check("stall_rd_addr", DW'(s_rd_a), DW'(32'h140));
`endif

    // Random traffic over a handful of blocks, with occasional resets.
    do_reset();
    hold_v = 1'b0;
    hold_a = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        step(1'b1, 32'h20, rnd_blk(), 1'b0, '0);
        rst_n = 1'b1;
        hold_v = 1'b0;
        continue;
      end
      ev_v = ($urandom_range(0, 99) < 50);
      ea   = (AW'($urandom_range(1, 6)) << OFF) | AW'($urandom_range(0, 31));
      if (hold_v) begin
        m_v = 1'b1;
        ma  = hold_a;
      end else begin
        m_v = ($urandom_range(0, 99) < 40);
        ma  = (AW'($urandom_range(1, 6)) << OFF) | AW'($urandom_range(0, 31));
      end
      step(ev_v, ea, rnd_blk(), m_v, ma);
      hold_v = s_stall;
      hold_a = ma;
    end
    idle_all();

    // Deep gap instance: fill, block the fifth eviction, then coalesce while full.
    step15(1'b1, 32'h040, rnd_blk());
    step15(1'b1, 32'h100, rnd_blk());
    check("full_first_drain", DW'(s15_wr_v), DW'(1));
    step15(1'b1, 32'h180, rnd_blk());
    step15(1'b1, 32'h200, rnd_blk());
    step15(1'b1, 32'h280, rnd_blk());
    check("full_count", DW'(bus15.count_o), DW'(4));
    acc_at = -1;
    for (int i = 0; i < 40 && acc_at < 0; i++) begin
      step15(1'b1, 32'h300, rnd_blk());
      check("full_ready", DW'(s15_ready), DW'(i == 12));
      if (s15_ready) begin
        acc_at = i;
        check("full_accept_drain", DW'(s15_wr_v), DW'(1));
        check("full_drain_addr", DW'(s15_wr_a), DW'(32'h100));
      end
    end
    check("full_accepted_at", DW'(acc_at), DW'(12));
    check("full_count_after", DW'(bus15.count_o), DW'(4));

    for (int i = 0; i < DW / 8; i++) daa[i*8 +: 8] = 8'hAA;
    step15(1'b1, 32'h200, daa);
    check("coal_ready", DW'(s15_ready), DW'(1));
    check("coal_count", DW'(bus15.count_o), DW'(4));
    nwr = 0;
    for (int i = 0; i < 80 && nwr < 2; i++) begin
      step15(1'b0, '0, '0);
      if (s15_wr_v) begin
        if (nwr == 0) check("coal_order", DW'(s15_wr_a), DW'(32'h180));
        else begin
          check("coal_addr", DW'(s15_wr_a), DW'(32'h200));
          check("coal_data", s15_wr_d, daa);
        end
        nwr++;
      end
    end
    check("coal_writes_seen", DW'(nwr), DW'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
